// File: rtl/uart_lite_slave.sv
// AXI4-Lite UART slave: RX/TX byte FIFOs, 8N1 serializer/deserializer, fixed baud divisor.
// Register map: 0x0 RX pop, 0x4 TX push, 0x8 STAT (read clears error flags), 0xC CTRL (flushes).

module uart_lite_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module uart_lite_slave #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [3:0]  AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  output logic        TX,
  input  logic        RX
);
  localparam int CW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_e;

  logic          aw_held, w_held, do_wr;
  logic [3:0]    awaddr_q;
  logic [7:0]    wdata_q;
  logic          wstrb0_q;
  logic          ar_hs, stat_rd, rx_pop;
  logic [31:0]   stat, rd_word;
  logic          frame_err, overrun, fe_set, ovr_set;
  logic          tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic          rx_push, rx_flush, rx_empty, rx_full;
  logic [7:0]    tx_head, rx_head;
  uart_st_e      tx_st, rx_st;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0]    tx_bit, rx_bit;
  logic [7:0]    tx_sh, rx_sh;
  logic          tx_end, rx_end;
  logic          rx_s1, rx_s2, rx_prev, rx_fall;
  logic          unused_ok;

  assign unused_ok = ^{WDATA[31:8], WSTRB[3:1]};

  // ---- read channel ----
  assign ARREADY = !RVALID;
  assign RRESP   = 2'b00;
  assign ar_hs   = ARVALID && ARREADY;
  assign stat_rd = ar_hs && (ARADDR == 4'h8);
  assign rx_pop  = ar_hs && (ARADDR == 4'h0);
  assign stat    = {25'b0, frame_err, overrun, 1'b0, tx_full, tx_empty, rx_full, !rx_empty};

  always_comb begin
    rd_word = '0;
    case (ARADDR)
      4'h0:    rd_word = rx_empty ? 32'h0 : {24'b0, rx_head};
      4'h8:    rd_word = stat;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
    end else if (ar_hs) begin
      RVALID <= 1'b1;
      RDATA  <= rd_word;
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end

  // ---- write channel: AW and W latch independently, write fires once both are held ----
  assign AWREADY  = !aw_held && !BVALID;
  assign WREADY   = !w_held && !BVALID;
  assign BRESP    = 2'b00;
  assign do_wr    = aw_held && w_held;
  assign tx_push  = do_wr && (awaddr_q == 4'h4) && wstrb0_q;
  assign tx_flush = do_wr && (awaddr_q == 4'hC) && wdata_q[0];
  assign rx_flush = do_wr && (awaddr_q == 4'hC) && wdata_q[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb0_q <= 1'b0;
      BVALID   <= 1'b0;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_held  <= 1'b1;
        awaddr_q <= AWADDR;
      end
      if (WVALID && WREADY) begin
        w_held   <= 1'b1;
        wdata_q  <= WDATA[7:0];
        wstrb0_q <= WSTRB[0];
      end
      if (do_wr) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
      end else if (BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  // A flag raised in the same cycle as a STAT read survives the read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (fe_set)       frame_err <= 1'b1;
      else if (stat_rd) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (stat_rd) overrun   <= 1'b0;
    end
  end

  uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .CLK(CLK), .RST(RST), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(wdata_q), .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .CLK(CLK), .RST(RST), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_sh), .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // ---- TX: the next byte is loaded at the end of STOP so frames run back to back ----
  assign tx_end = (tx_cnt == CW'(BAUD_DIV - 1));
  assign tx_pop = ((tx_st == IDLE) || ((tx_st == STOP) && tx_end)) && !tx_empty && !tx_flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_st  <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      TX     <= 1'b1;
    end else begin
      tx_cnt <= tx_end ? '0 : tx_cnt + CW'(1);
      case (tx_st)
        IDLE: begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_st <= START;
            tx_sh <= tx_head;
            TX    <= 1'b0;
          end
        end
        START: if (tx_end) begin
          tx_st  <= DATA;
          tx_bit <= '0;
          TX     <= tx_sh[0];
        end
        DATA: if (tx_end) begin
          if (tx_bit == 3'd7) begin
            tx_st <= STOP;
            TX    <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            TX     <= tx_sh[1];
          end
        end
        STOP: if (tx_end) begin
          if (tx_pop) begin
            tx_st <= START;
            tx_sh <= tx_head;
            TX    <= 1'b0;
          end else begin
            tx_st <= IDLE;
          end
        end
        default: tx_st <= IDLE;
      endcase
    end
  end

  // ---- RX: 2-FF synchronizer, mid-bit sampling after start-bit re-check ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_end  = (rx_cnt == CW'(BAUD_DIV - 1));
  assign fe_set  = (rx_st == STOP) && rx_end && !rx_s2;
  assign ovr_set = (rx_st == STOP) && rx_end && rx_s2 && rx_full;
  assign rx_push = (rx_st == STOP) && rx_end && rx_s2 && !rx_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_st  <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_cnt <= rx_end ? '0 : rx_cnt + CW'(1);
      case (rx_st)
        IDLE: begin
          rx_cnt <= '0;
          if (rx_fall) rx_st <= START;
        end
        START: if (rx_cnt == CW'(BAUD_DIV / 2 - 1)) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? IDLE : DATA;
        end
        DATA: if (rx_end) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= STOP;
        end
        STOP: if (rx_end) rx_st <= IDLE;
        default: rx_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_lite_slave.sv
// Bench for uart_lite_slave: register table, directed corner sequences, and random
// RX/TX traffic checked against a queue model and a line-level UART decoder.

module tb_uart_lite_slave;
  localparam int BD  = 16;
  localparam int DEP = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [3:0]  AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic        TX;
  logic        RX = 1'b1;

  int   errors = 0, checks = 0;
  bit   mon_en = 1'b0;
  logic [7:0] tx_got[$], tx_exp[$], rx_q[$];
  bit   m_fe = 1'b0, m_ovr = 1'b0;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[9];

  uart_lite_slave #(.BAUD_DIV(BD), .FIFO_DEPTH(DEP)) dut (
    .CLK(CLK), .RST(RST),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .TX(TX), .RX(RX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input bit txf, input bit txe);
    return {25'b0, m_fe, m_ovr, 1'b0, txf, txe, rx_q.size() == DEP, rx_q.size() != 0};
  endfunction

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge CLK);
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge CLK); n++; end
    ARADDR = a; ARVALID = 1'b1;
    @(negedge CLK);
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin @(negedge CLK); n++; end
    if (!RVALID) chk("rvalid_timeout", 32'(RVALID), 32'd1);
    d = RDATA;
    chk("rresp", 32'(RRESP), 32'd0);
    RREADY = 1'b1;
    @(negedge CLK);
    RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int lat;
    for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
      @(negedge CLK);
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      #1;
      if (w_done && !aw_done) chk("wready_while_held", 32'(WREADY), 32'd0);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge CLK);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
    end
    @(negedge CLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!(aw_done && w_done)) chk("aw_w_accept_timeout", 32'(aw_done && w_done), 32'd1);
    lat = 0;
    while (!BVALID && lat < 20) begin @(negedge CLK); lat++; end
    chk("b_latency", 32'(lat), 32'd1);
    for (int i = 0; i < b_dly; i++) begin
      chk("awready_during_b", 32'(AWREADY), 32'd0);
      chk("wready_during_b", 32'(WREADY), 32'd0);
      chk("bvalid_hold", 32'(BVALID), 32'd1);
      @(negedge CLK);
    end
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge CLK);
    BREADY = 1'b0;
    chk("bvalid_clear", 32'(BVALID), 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, 0, 0, 0, r);
    chk("bresp", 32'(r), 32'd0);
  endtask

  task automatic rd_stat(input string name, input bit txf, input bit txe);
    logic [31:0] d;
    axi_read(4'h8, d);
    chk(name, d, exp_stat(txf, txe));
    m_fe = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic drain(input string name);
    logic [31:0] d, e;
    int n = rx_q.size();
    for (int i = 0; i <= n; i++) begin
      axi_read(4'h0, d);
      e = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
      chk(name, d, e);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge CLK); RX = 1'b0;
    repeat (BD) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin RX = b[i]; repeat (BD) @(negedge CLK); end
    RX = stop;
    repeat (BD) @(negedge CLK);
    RX = 1'b1;
    repeat (4) @(negedge CLK);
    if (!stop)                   m_fe = 1'b1;
    else if (rx_q.size() == DEP) m_ovr = 1'b1;
    else                         rx_q.push_back(b);
  endtask

  task automatic wait_tx(input int n);
    int c = 0;
    while (tx_got.size() < n && c < 20 * BD * (n + 1)) begin @(negedge CLK); c++; end
    chk("tx_count", 32'(tx_got.size()), 32'(n));
    while (tx_got.size() != 0 && tx_exp.size() != 0)
      chk("tx_byte", 32'(tx_got.pop_front()), 32'(tx_exp.pop_front()));
    tx_got.delete(); tx_exp.delete();
  endtask

  task automatic measure_low(output int len);
    int n = 0;
    len = 0;
    while (TX !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
    while (TX === 1'b0 && len < 4 * BD) begin @(negedge CLK); len++; end
  endtask

  // Line-level decoder: samples each bit in its middle, starting from the first low sample.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge CLK);
      if (mon_en && TX === 1'b0) begin
        repeat (BD / 2) @(negedge CLK);
        chk("tx_start_bit", 32'(TX), 32'd0);
        for (int i = 0; i < 8; i++) begin repeat (BD) @(negedge CLK); b[i] = TX; end
        repeat (BD) @(negedge CLK);
        chk("tx_stop_bit", 32'(TX), 32'd1);
        tx_got.push_back(b);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  b;
    int          k, low;

    vt[0] = '{0, 4'h0, 32'h0,   4'h0, 32'h0};
    vt[1] = '{0, 4'h4, 32'h0,   4'h0, 32'h0};
    vt[2] = '{0, 4'h8, 32'h0,   4'h0, 32'h4};
    vt[3] = '{0, 4'hC, 32'h0,   4'h0, 32'h0};
    vt[4] = '{1, 4'h0, 32'hFF,  4'hF, 32'h0};
    vt[5] = '{1, 4'h8, 32'hFF,  4'hF, 32'h0};
    vt[6] = '{1, 4'hC, 32'h0,   4'hF, 32'h0};
    vt[7] = '{1, 4'h4, 32'hA5,  4'hE, 32'h0};
    vt[8] = '{0, 4'h8, 32'h0,   4'h0, 32'h4};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd1);
    chk("rst_awready", 32'(AWREADY), 32'd1);
    chk("rst_wready", 32'(WREADY), 32'd1);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_bresp", 32'(BRESP), 32'd0);
    RST = 1'b0;

    // T1: reset in the middle of a TX frame
    wr(4'h4, 32'h55);
    repeat (3 * BD) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_tx", 32'(TX), 32'd1);
    chk("midrst_rvalid", 32'(RVALID), 32'd0);
    chk("midrst_bvalid", 32'(BVALID), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    rd_stat("midrst_stat", 0, 1);
    mon_en = 1'b1;

    // Register table
    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].wdata, vt[i].strb, 0, 0, 0, r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), vt[i].exp);
      end else begin
        axi_read(vt[i].addr, d);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp);
      end
    end

    // T2: single TX byte, start bit exactly BD clocks
    fork
      wr(4'h4, 32'h41);
      measure_low(low);
    join
    chk("t2_start_len", 32'(low), 32'(BD));
    tx_exp.push_back(8'h41);
    wait_tx(1);

    // T4: W leads AW by 3 cycles, BREADY held off 5 cycles
    axi_write(4'h4, 32'h3C, 4'h1, 3, 0, 5, r);
    chk("t4_bresp", 32'(r), 32'd0);
    tx_exp.push_back(8'h3C);
    wait_tx(1);

    // T3: one RX byte
    send_rx(8'h5A, 1'b1);
    rd_stat("t3_stat_valid", 0, 1);
    drain("t3_rx_byte");
    rd_stat("t3_stat_empty", 0, 1);

    // T5: overrun after FIFO_DEPTH+1 frames
    for (int i = 0; i <= DEP; i++) send_rx(8'($urandom), 1'b1);
    rd_stat("t5_stat_ovr", 0, 1);
    rd_stat("t5_stat_clr", 0, 1);
    drain("t5_rx_order");

    // T6: framing error, then a short glitch
    send_rx(8'hC3, 1'b0);
    rd_stat("t6_stat_fe", 0, 1);
    drain("t6_no_byte");
    @(negedge CLK); RX = 1'b0;
    repeat (BD / 4) @(negedge CLK);
    RX = 1'b1;
    repeat (3 * BD) @(negedge CLK);
    rd_stat("t6_glitch_stat", 0, 1);
    drain("t6_glitch_no_byte");

    // TX FIFO full: one byte in flight plus DEP queued, the rest dropped
    for (int i = 0; i < DEP + 2; i++) begin
      b = 8'(8'h10 + i);
      wr(4'h4, {24'b0, b});
      if (i <= DEP) tx_exp.push_back(b);
    end
    rd_stat("txfull_stat", 1, 0);
    wait_tx(DEP + 1);

    // Flushes
    wr(4'h4, 32'h61); wr(4'h4, 32'h62); wr(4'h4, 32'h63);
    wr(4'hC, 32'h1);
    tx_exp.push_back(8'h61);
    rd_stat("txflush_stat", 0, 1);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    wr(4'hC, 32'h2);
    rx_q.delete();
    rd_stat("rxflush_stat", 0, 1);
    drain("rxflush_empty");
    wait_tx(1);

    // Random traffic
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, DEP + 1);
        for (int j = 0; j < k; j++) send_rx(8'($urandom), 1'b1);
        rd_stat("rnd_stat", 0, 1);
        drain("rnd_rx_byte");
      end else begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) begin
          b = 8'($urandom);
          axi_write(4'h4, {24'b0, b}, 4'h1, $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), r);
          chk("rnd_bresp", 32'(r), 32'd0);
          tx_exp.push_back(b);
        end
        wait_tx(k);
      end
    end

    repeat (12 * BD) @(negedge CLK);
    chk("no_extra_tx", 32'(tx_got.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
